comma_aligner: RTL and testbench

- Consumes the 2-bit sampled stream from the fast-readout data receiver; data[0] carries the newest serial bit each enabled cycle.
- Finds the 8b10b K28.5 comma in the serial bit stream and establishes 10-bit word alignment with a SEARCH/VERIFY/LOCKED state machine.
- Once locked, outputs aligned 10-bit words, still 8b10b-encoded, to the downstream decoder and FIFO.
- Reports lock status and counts realignments.

---
 rtl/comma_aligner.sv | 157 +++++++++++++++
 tb/tb_comma_aligner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner.sv
// K28.5 comma aligner: finds the comma in the serial bit stream, verifies word
// alignment over several commas, then emits aligned 10-bit words while watching for slip.
module comma_aligner #(
  parameter logic [9:0]  COMMA_P        = 10'b0011111010,
  parameter logic [9:0]  COMMA_N        = 10'b1100000101,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned MISALIGN_LIMIT = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       bit_valid,
  input  logic [1:0] data,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       word_is_comma,
  output logic       locked,
  output logic [7:0] realign_count
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] MIS_LIM  = 4'(MISALIGN_LIMIT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [9:0] shreg_r, nxt_s;
  logic [3:0] bitcnt_r, bitcnt_s;
  logic [3:0] commacnt_r, commacnt_s;
  logic [3:0] miscnt_r, miscnt_s;
  logic       comma_hit_s, boundary_s;
  logic       emit_s, drop_s, locked_s;
  logic [9:0] word_s;
  logic       word_valid_s, word_is_comma_s;
  logic [7:0] realign_s;
  logic       unused_data;

  function automatic logic is_comma(input logic [9:0] w);
    return (w == COMMA_P) || (w == COMMA_N);
  endfunction

  assign unused_data = data[1];

  // Candidate shift-register contents and the comma/boundary flags derived from them.
  always_comb begin
    nxt_s       = {shreg_r[8:0], data[0]};
    comma_hit_s = is_comma(nxt_s);
    boundary_s  = (bitcnt_r == 4'd9);
  end

  // State and alignment counters register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= SEARCH;
      bitcnt_r   <= 4'd0;
      commacnt_r <= 4'd0;
      miscnt_r   <= 4'd0;
    end else begin
      state_r    <= state_s;
      bitcnt_r   <= bitcnt_s;
      commacnt_r <= commacnt_s;
      miscnt_r   <= miscnt_s;
    end
  end

  // Next-state logic: acquire, verify and track the word boundary.
  always_comb begin
    state_s    = state_r;
    bitcnt_s   = bitcnt_r;
    commacnt_s = commacnt_r;
    miscnt_s   = miscnt_r;
    if (bit_valid) begin
      bitcnt_s = boundary_s ? 4'd0 : bitcnt_r + 4'd1;
      case (state_r)
        SEARCH: begin
          bitcnt_s = 4'd0;
          if (comma_hit_s) begin
            commacnt_s = 4'd1;
            state_s    = (LOCK_CNT == 4'd1) ? LOCKED : VERIFY;
          end else begin
            commacnt_s = 4'd0;
            state_s    = SEARCH;
          end
        end
        VERIFY: begin
          if (boundary_s && comma_hit_s) begin
            commacnt_s = commacnt_r + 4'd1;
            state_s    = ((commacnt_r + 4'd1) == LOCK_CNT) ? LOCKED : VERIFY;
          end else if (boundary_s) begin
            commacnt_s = 4'd0;
            state_s    = SEARCH;
          end else begin
            state_s    = VERIFY;
          end
        end
        LOCKED: begin
          // The comma that trips the limit is consumed here, so search restarts on the next bit.
          if (boundary_s && comma_hit_s) begin
            miscnt_s = 4'd0;
          end else if (comma_hit_s && ((miscnt_r + 4'd1) == MIS_LIM)) begin
            state_s    = SEARCH;
            bitcnt_s   = 4'd0;
            commacnt_s = 4'd0;
            miscnt_s   = 4'd0;
          end else if (comma_hit_s) begin
            miscnt_s = miscnt_r + 4'd1;
          end else begin
            miscnt_s = miscnt_r;
          end
        end
        default: begin
          state_s    = SEARCH;
          bitcnt_s   = 4'd0;
          commacnt_s = 4'd0;
          miscnt_s   = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output logic: word strobe at each locked boundary and on the lock-completing comma.
  always_comb begin
    emit_s          = bit_valid && (((state_r == LOCKED) && boundary_s) ||
                                    ((state_r != LOCKED) && (state_s == LOCKED)));
    drop_s          = bit_valid && (state_r == LOCKED) && (state_s == SEARCH);
    locked_s        = (state_s == LOCKED);
    word_s          = emit_s ? nxt_s : word;
    word_valid_s    = emit_s;
    word_is_comma_s = emit_s ? comma_hit_s : word_is_comma;
    realign_s       = (drop_s && (realign_count != 8'hFF)) ? realign_count + 8'd1 : realign_count;
  end

  // Shift register and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_r       <= 10'd0;
      word          <= 10'd0;
      word_valid    <= 1'b0;
      word_is_comma <= 1'b0;
      locked        <= 1'b0;
      realign_count <= 8'd0;
    end else begin
      shreg_r       <= bit_valid ? nxt_s : shreg_r;
      word          <= word_s;
      word_valid    <= word_valid_s;
      word_is_comma <= word_is_comma_s;
      locked        <= locked_s;
      realign_count <= realign_s;
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: a bit-index based reference model checked every cycle,
// plus directed literal checks on the scenarios of interest.
module tb_comma_aligner;

  localparam logic [9:0] CP  = 10'b0011111010;
  localparam logic [9:0] CN  = 10'b1100000101;
  localparam logic [9:0] D21 = 10'b1010101010;
  localparam int LC = 4;
  localparam int ML = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       bit_valid = 1'b0;
  logic [1:0] data = 2'b00;
  logic [9:0] word;
  logic       word_valid, word_is_comma, locked;
  logic [7:0] realign_count;

  int tests = 0;
  int fails = 0;

  comma_aligner #(.COMMA_P(CP), .COMMA_N(CN), .LOCK_COUNT(LC), .MISALIGN_LIMIT(ML)) dut (
    .clock(clock), .reset_n(reset_n), .bit_valid(bit_valid), .data(data),
    .word(word), .word_valid(word_valid), .word_is_comma(word_is_comma),
    .locked(locked), .realign_count(realign_count)
  );

  always #5 clock = ~clock;

  // Reference model: alignment expressed as "bits since the anchoring comma mod 10".
  typedef struct packed {
    logic [1:0] mode;   // 0 hunting, 1 confirming, 2 locked
    int         n;
    int         anchor;
    int         hits;
    int         mis;
    logic [9:0] hist;
    logic [9:0] word;
    logic       wv;
    logic       wic;
    logic       lk;
    logic [7:0] rc;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t c, input logic v, input logic b);
    model_t r;
    logic   hit, bnd;
    r    = c;
    r.wv = 1'b0;
    if (v) begin
      r.hist = {c.hist[8:0], b};
      r.n    = c.n + 1;
      hit    = (r.hist == CP) || (r.hist == CN);
      bnd    = (r.n > c.anchor) && (((r.n - c.anchor) % 10) == 0);
      if (c.mode == 2'd0) begin
        if (hit) begin
          r.anchor = r.n;
          r.hits   = 1;
          r.mode   = 2'd1;
          if (LC == 1) begin
            r.mode = 2'd2; r.lk = 1'b1; r.wv = 1'b1; r.word = r.hist; r.wic = 1'b1;
          end
        end
      end else if (c.mode == 2'd1) begin
        if (bnd && hit) begin
          r.hits = c.hits + 1;
          if (r.hits == LC) begin
            r.mode = 2'd2; r.lk = 1'b1; r.wv = 1'b1; r.word = r.hist; r.wic = 1'b1;
          end
        end else if (bnd) begin
          r.mode = 2'd0;
          r.hits = 0;
        end
      end else begin
        if (bnd) begin
          r.wv = 1'b1; r.word = r.hist; r.wic = hit;
          if (hit) r.mis = 0;
        end else if (hit) begin
          r.mis = c.mis + 1;
          if (r.mis == ML) begin
            r.mode = 2'd0; r.lk = 1'b0; r.hits = 0; r.mis = 0;
            if (c.rc != 8'hFF) r.rc = c.rc + 8'd1;
          end
        end
      end
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else          m <= model_next(m, bit_valid, data[0]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("locked", {31'd0, locked}, {31'd0, m.lk});
    check("word_valid", {31'd0, word_valid}, {31'd0, m.wv});
    check("realign_count", {24'd0, realign_count}, {24'd0, m.rc});
    check("word", {22'd0, word}, {22'd0, m.word});
    check("word_is_comma", {31'd0, word_is_comma}, {31'd0, m.wic});
  end

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    data      = {~b, b};
    @(posedge clock);
    #2;
    bit_valid = 1'b0;
  endtask

  task automatic send_part(input logic [9:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [9:0] w);
    send_part(w, 9, 0);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    logic [9:0] garbage;
    garbage = 10'b0000010110;
    #1 reset_n = 1'b0;
    #3;
    check("reset locked", {31'd0, locked}, 32'd0);
    check("reset word_valid", {31'd0, word_valid}, 32'd0);
    check("reset word", {22'd0, word}, 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;

    // Garbage then commas: lock on the fourth aligned comma.
    send_part(garbage, 4, 0);
    for (int k = 0; k < 3; k++) send_word(CP);
    check("t1 not yet locked", {31'd0, locked}, 32'd0);
    send_word(CP);
    check("t1 locked", {31'd0, locked}, 32'd1);
    check("t1 strobe", {31'd0, word_valid}, 32'd1);
    check("t1 word", {22'd0, word}, 32'h0FA);
    check("t1 is_comma", {31'd0, word_is_comma}, 32'd1);
    send_word(CP);
    send_word(CP);

    // Comma then D21.5 data word.
    send_word(CP);
    send_word(D21);
    check("t2 strobe", {31'd0, word_valid}, 32'd1);
    check("t2 word", {22'd0, word}, 32'h2AA);
    check("t2 is_comma", {31'd0, word_is_comma}, 32'd0);

    // Gap of seven idle cycles in the middle of a word.
    send_part(CP, 9, 6);
    idle(7);
    check("t3 word held", {22'd0, word}, 32'h2AA);
    send_part(CP, 5, 0);
    check("t3 strobe", {31'd0, word_valid}, 32'd1);
    check("t3 word", {22'd0, word}, 32'h0FA);

    // One-bit slip, then RD+ commas at the new alignment.
    send_bit(1'b0);
    for (int k = 0; k < 3; k++) send_word(CN);
    check("t4 unlocked", {31'd0, locked}, 32'd0);
    check("t4 realign", {24'd0, realign_count}, 32'd1);
    for (int k = 0; k < 3; k++) send_word(CN);
    check("t4 not relocked", {31'd0, locked}, 32'd0);
    send_word(CN);
    check("t4 relocked", {31'd0, locked}, 32'd1);
    check("t4 word", {22'd0, word}, 32'h305);
    send_word(CN);

    // Asynchronous reset in the middle of a word while locked.
    send_part(CN, 9, 5);
    reset_n = 1'b0;
    #1;
    check("t6 locked", {31'd0, locked}, 32'd0);
    check("t6 word_valid", {31'd0, word_valid}, 32'd0);
    check("t6 word", {22'd0, word}, 32'd0);
    check("t6 realign", {24'd0, realign_count}, 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;

    // Comma followed by non-comma: back to hunting, then lock at a new phase.
    send_word(CP);
    send_word(D21);
    check("t5 never locked", {31'd0, locked}, 32'd0);
    send_part(garbage, 7, 5);
    for (int k = 0; k < 3; k++) send_word(CP);
    check("t5 still unlocked", {31'd0, locked}, 32'd0);
    send_word(CP);
    check("t5 locks at new phase", {31'd0, locked}, 32'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
